// File: rtl/bram_filter_sched_if.sv
// Stream handshakes between the upstream disparity/gray sources, the filter inputs
// and the filter output monitor. slave is the scheduler's view, master the environment's.
interface bram_filter_sched_if;
  logic [15:0] disp_conf_in_data;
  logic        disp_conf_in_valid;
  logic        disp_conf_in_ready;
  logic [7:0]  gray_in_data;
  logic        gray_in_valid;
  logic        gray_in_ready;
  logic [15:0] disp_conf_out_data;
  logic        disp_conf_out_valid;
  logic        disp_conf_out_ready;
  logic [7:0]  gray_out_data;
  logic        gray_out_valid;
  logic        gray_out_ready;
  logic        filt_out_valid;
  logic        filt_out_ready;

  modport slave (
    input  disp_conf_in_data, disp_conf_in_valid, gray_in_data, gray_in_valid,
    input  disp_conf_out_ready, gray_out_ready, filt_out_valid, filt_out_ready,
    output disp_conf_in_ready, gray_in_ready,
    output disp_conf_out_data, disp_conf_out_valid, gray_out_data, gray_out_valid
  );

  modport master (
    output disp_conf_in_data, disp_conf_in_valid, gray_in_data, gray_in_valid,
    output disp_conf_out_ready, gray_out_ready, filt_out_valid, filt_out_ready,
    input  disp_conf_in_ready, gray_in_ready,
    input  disp_conf_out_data, disp_conf_out_valid, gray_out_data, gray_out_valid
  );
endinterface

// File: rtl/bram_filter_sched.sv
// Paces one frame of paired disparity/gray pixels into the filter (both or neither
// per cycle) and tracks filter output beats until the frame has fully drained.
module bram_filter_sched #(
  parameter int dec_frame_w = 80,
  parameter int dec_frame_h = 160,
  parameter int pace_div    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  bram_filter_sched_if.slave   bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_overrun
);

  localparam int N  = dec_frame_w * dec_frame_h;
  localparam int CW = $clog2(N + 1);
  localparam int PW = (pace_div > 1) ? $clog2(pace_div) : 1;

  localparam logic [CW-1:0] N_C       = CW'(N);
  localparam logic [CW-1:0] N_M1      = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PACE_LAST = PW'(pace_div - 1);
  localparam logic [PW-1:0] PACE_ONE  = PW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [PW-1:0] pace_cnt;
  logic          start_acc, tick, base, fire, beat, in_last, out_reach;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here by straight-line assignment) so no latch is inferred.
  always_comb begin
    start_acc = (state == IDLE) && start;
    tick      = (pace_cnt == '0);
    base      = (state == RUN) && tick && bus.disp_conf_in_valid && bus.gray_in_valid;
    fire      = base && bus.disp_conf_out_ready && bus.gray_out_ready;
    beat      = bus.filt_out_valid && bus.filt_out_ready;
    in_last   = fire && (in_cnt == N_M1);
    out_reach = (out_cnt == N_C) || (beat && (out_cnt == N_M1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = RUN;
      RUN:     if (in_last)   state_nxt = DRAIN;
      DRAIN:   if (out_reach) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Each side only sees valid when the other side can take its beat too.
  always_comb begin
    busy                    = (state != IDLE);
    bus.disp_conf_out_valid = base && bus.gray_out_ready;
    bus.gray_out_valid      = base && bus.disp_conf_out_ready;
    bus.disp_conf_in_ready  = fire;
    bus.gray_in_ready       = fire;
    bus.disp_conf_out_data  = bus.disp_conf_in_data;
    bus.gray_out_data       = bus.gray_in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      pace_cnt <= '0;
    end else if (start_acc) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      pace_cnt <= '0;
    end else begin
      if (state == RUN)
        pace_cnt <= (pace_cnt == PACE_LAST) ? '0 : pace_cnt + PACE_ONE;
      if (fire)
        in_cnt <= in_cnt + CNT_ONE;
      if ((state != IDLE) && beat && (out_cnt != N_C))
        out_cnt <= out_cnt + CNT_ONE;
    end
  end

  // A beat with nothing outstanding wins over the clear from a same-cycle start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && (state_nxt == IDLE);
      if (beat && ((out_cnt == N_C) || (state == IDLE)))
        err_overrun <= 1'b1;
      else if (start_acc)
        err_overrun <= 1'b0;
    end
  end

endmodule

// File: doc/bram_filter_sched.md
BRAM_FILTER_SCHED -- requirements
Module: bram_filter_sched

Interface
REQ-001 SHALL have parameter dec_frame_w, default 80, meaning decimated frame width in pixels.
REQ-002 SHALL have parameter dec_frame_h, default 160, meaning decimated frame height in rows.
REQ-003 SHALL have parameter pace_div, default 2, meaning one issue slot every pace_div cycles; legal range 1..16.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  in  1  frame start request, sampled in IDLE only.
REQ-007 SHALL have port disp_conf_in_data / _valid / _ready  in/in/out  16/1/1  upstream disparity+confidence stream.
REQ-008 SHALL have port gray_in_data / _valid / _ready  in/in/out  8/1/1  upstream gray stream.
REQ-009 SHALL have port disp_conf_out_data / _valid / _ready  out/out/in  16/1/1  to filter disp_conf input.
REQ-010 SHALL have port gray_out_data / _valid / _ready  out/out/in  8/1/1  to filter gray input.
REQ-011 SHALL have port filt_out_valid / filt_out_ready  in/in  1/1  filter output handshake, monitored only.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse at frame completion.
REQ-014 SHALL have port err_overrun  out  1  sticky error flag.

Function
REQ-015 SHALL define N = dec_frame_w*dec_frame_h; in_cnt and out_cnt SHALL be clog2(N+1) bits wide and never wrap.
REQ-016 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start (next cycle), RUN->DRAIN when in_cnt reaches N, DRAIN->IDLE when out_cnt reaches N.
REQ-017 SHALL clear in_cnt, out_cnt, pace counter on IDLE->RUN.
REQ-018 SHALL run pace counter 0..pace_div-1 free-running in RUN; tick = (pace counter == 0); pace_div=1 gives tick every cycle.
REQ-019 SHALL define base = RUN & tick & disp_conf_in_valid & gray_in_valid.
REQ-020 SHALL drive disp_conf_out_valid = base & gray_out_ready and gray_out_valid = base & disp_conf_out_ready, so both sides transfer in the same cycle or neither.
REQ-021 SHALL define fire = base & disp_conf_out_ready & gray_out_ready; both *_in_ready SHALL equal fire; in_cnt increments on fire.
REQ-022 SHALL pass data combinationally (zero latency): *_out_data = *_in_data.
REQ-023 SHALL never fire in IDLE or DRAIN; all in_ready and out_valid low there.
REQ-024 SHALL increment out_cnt on filt_out_valid & filt_out_ready in RUN or DRAIN, saturating at N.
REQ-025 SHALL, when in_cnt reaches N and out_cnt already equals N (or reaches N same cycle), pass through DRAIN for exactly one cycle then IDLE.
REQ-026 SHALL assert frame_done for one cycle in the first IDLE cycle after DRAIN.
REQ-027 SHALL set err_overrun on a filter output beat while out_cnt == N or while in IDLE; cleared only by reset or start accepted in IDLE.
REQ-028 SHALL ignore start while busy; start asserted in the same cycle as frame_done SHALL be accepted.

Reset
REQ-029 SHALL, on reset_n low, asynchronously force state IDLE, all counters 0, busy 0, frame_done 0, err_overrun 0, all ready/valid outputs 0.
REQ-030 SHALL, on reset mid-frame, discard progress; a new start after release begins a fresh frame with in_cnt = 0.

Verification (dec_frame_w=4, dec_frame_h=2, N=8)
REQ-031 SHALL verify: pace_div=2, both inputs always valid, outputs always ready, start pulse -> exactly 8 fires on alternate cycles, then DRAIN; 8 filter beats -> frame_done one cycle, busy low.
REQ-032 SHALL verify: gray_out_ready low while disp_conf_out_ready high -> no valid on disp_conf_out, no in_ready, in_cnt unchanged.
REQ-033 SHALL verify: gray_in_valid low for 5 cycles mid-frame -> no fires; resume -> total still exactly 8 fires, data order preserved.
REQ-034 SHALL verify: 9th filter output beat -> err_overrun = 1 and stays 1 until next accepted start.
REQ-035 SHALL verify: reset_n low after 3 fires -> all outputs 0 immediately; start after release -> 8 new fires, frame_done once.
REQ-036 SHALL verify: pace_div=1, filter beats concurrent with input, 8th output beat in same cycle as 8th fire -> one DRAIN cycle, frame_done next cycle.
